// File: rtl/nbdcache_port_ctrl.sv
// Per-port controller of the non-blocking L1 data cache (one per core port).
// Accepts a request, reads all ways at the index and waits for the late tag.
// It then answers a load hit, writes a store hit, or hands misses and
// uncached accesses to the shared miss handler.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   bypass_i                 cache disabled, every access is uncached
//   busy_o                   controller not idle
//   req_*                    core request, grant, load response
//   sram_*                   per-way array request/write and read data
//   hit_way_i                one-hot hit vector from the shared tag comparator
//   miss_*, bypass_*         request/handshake towards the miss handler
//   active_serving_i,
//   critical_word_*          refill progress for this port
//   mshr_*                   current address and MSHR conflict flags
//
// state       | meaning
// IDLE        | no request, array requested as soon as req_valid_i is seen
// WAIT_TAG    | array read done, waiting for the late tag or kill
// STORE_REQ   | writing a store hit into the saved way
// MISS_REQ    | miss request presented to the miss handler
// WAIT_REFILL | waiting for critical word (load) or end of refill (store)
// WAIT_MSHR   | index conflicts with an MSHR, replay array read once clear
// BYPASS_REQ  | uncached request presented to the miss handler
// BYPASS_WAIT | waiting for uncached data/ack
module nbdcache_port_ctrl #(
    parameter int unsigned SET_ASSOC   = 8,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = 44,
    parameter int unsigned LINE_WIDTH  = 128
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  bypass_i,
    output logic                                  busy_o,
    input  logic                                  req_valid_i,
    input  logic                                  req_we_i,
    input  logic                                  req_kill_i,
    input  logic                                  req_tag_valid_i,
    input  logic [INDEX_WIDTH-1:0]                req_index_i,
    input  logic [TAG_WIDTH-1:0]                  req_tag_i,
    input  logic [7:0]                            req_be_i,
    input  logic [1:0]                            req_size_i,
    input  logic [63:0]                           req_wdata_i,
    output logic                                  req_gnt_o,
    output logic                                  req_rvalid_o,
    output logic [63:0]                           req_rdata_o,
    output logic [SET_ASSOC-1:0]                  sram_req_o,
    output logic [INDEX_WIDTH-1:0]                sram_addr_o,
    input  logic                                  sram_gnt_i,
    input  logic [SET_ASSOC*LINE_WIDTH-1:0]       sram_rdata_i,
    input  logic [SET_ASSOC-1:0]                  hit_way_i,
    output logic [TAG_WIDTH-1:0]                  sram_tag_o,
    output logic                                  sram_we_o,
    output logic                                  sram_dirty_o,
    output logic [LINE_WIDTH-1:0]                 sram_wdata_o,
    output logic [LINE_WIDTH/8-1:0]               sram_be_o,
    output logic                                  miss_valid_o,
    output logic                                  miss_bypass_o,
    output logic                                  miss_we_o,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]      miss_addr_o,
    output logic [7:0]                            miss_be_o,
    output logic [1:0]                            miss_size_o,
    output logic [63:0]                           miss_wdata_o,
    input  logic                                  miss_gnt_i,
    input  logic                                  bypass_gnt_i,
    input  logic                                  bypass_valid_i,
    input  logic                                  active_serving_i,
    input  logic                                  critical_word_valid_i,
    input  logic [63:0]                           bypass_data_i,
    input  logic [63:0]                           critical_word_i,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]      mshr_addr_o,
    input  logic                                  mshr_addr_matches_i,
    input  logic                                  mshr_index_matches_i
);

    localparam int unsigned WORDS    = LINE_WIDTH / 64;
    localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE, WAIT_TAG, STORE_REQ, MISS_REQ, WAIT_REFILL, WAIT_MSHR, BYPASS_REQ, BYPASS_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   we_q;
    logic [7:0]             be_q;
    logic [1:0]             size_q;
    logic [63:0]            wdata_q;
    logic [SET_ASSOC-1:0]   way_q;
    logic                   tag_saved_q;
    logic                   serving_q;

    logic                   save_req, save_tag, save_way;
    logic [TAG_WIDTH-1:0]   tag_cur;
    logic [INDEX_WIDTH-4:0] word_idx;
    logic [LINE_WIDTH-1:0]  hit_line;
    logic [63:0]            hit_word;

    // The live tag is only taken from the core on the first pass through
    // WAIT_TAG; replays after an MSHR wait reuse the saved one.
    assign tag_cur     = (state_q == WAIT_TAG && !tag_saved_q) ? req_tag_i : tag_q;
    assign sram_tag_o  = tag_cur;
    assign mshr_addr_o = {tag_cur, index_q};
    assign busy_o      = (state_q != IDLE);

    // Only the index bits inside the line select the 64-bit word.
    assign word_idx = index_q[INDEX_WIDTH-1:3] & (INDEX_WIDTH-3)'(WORDS - 1);

    always_comb begin
        hit_line = '0;
        for (int w = 0; w < SET_ASSOC; w++)
            if (hit_way_i[w]) hit_line = hit_line | sram_rdata_i[w*LINE_WIDTH +: LINE_WIDTH];
    end

    always_comb begin
        hit_word = '0;
        for (int k = 0; k < WORDS; k++)
            if (word_idx == (INDEX_WIDTH-3)'(k)) hit_word = hit_line[k*64 +: 64];
    end

    always_comb begin
        state_d       = state_q;
        save_req      = 1'b0;
        save_tag      = 1'b0;
        save_way      = 1'b0;
        req_gnt_o     = 1'b0;
        req_rvalid_o  = 1'b0;
        req_rdata_o   = '0;
        sram_req_o    = '0;
        sram_addr_o   = '0;
        sram_we_o     = 1'b0;
        sram_dirty_o  = 1'b0;
        sram_wdata_o  = '0;
        sram_be_o     = '0;
        miss_valid_o  = 1'b0;
        miss_bypass_o = 1'b0;
        miss_we_o     = 1'b0;
        miss_addr_o   = '0;
        miss_be_o     = '0;
        miss_size_o   = '0;
        miss_wdata_o  = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    sram_req_o  = '1;
                    sram_addr_o = req_index_i;
                    if (sram_gnt_i) begin
                        req_gnt_o = 1'b1;
                        save_req  = 1'b1;
                        state_d   = WAIT_TAG;
                    end
                end
            end
            WAIT_TAG: begin
                if (req_kill_i) begin
                    state_d = IDLE;
                end else if (req_tag_valid_i || tag_saved_q) begin
                    save_tag = 1'b1;
                    if (bypass_i) begin
                        state_d = BYPASS_REQ;
                    end else if (mshr_index_matches_i) begin
                        state_d = WAIT_MSHR;
                    end else if (|hit_way_i) begin
                        if (we_q) begin
                            save_way = 1'b1;
                            state_d  = STORE_REQ;
                        end else begin
                            req_rvalid_o = 1'b1;
                            req_rdata_o  = hit_word;
                            state_d      = IDLE;
                        end
                    end else if (mshr_addr_matches_i) begin
                        state_d = WAIT_MSHR;
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            STORE_REQ: begin
                sram_req_o   = way_q;
                sram_addr_o  = index_q;
                sram_we_o    = 1'b1;
                sram_dirty_o = 1'b1;
                sram_wdata_o = {WORDS{wdata_q}};
                sram_be_o    = BE_WIDTH'(be_q) << {word_idx, 3'b000};
                if (sram_gnt_i) state_d = IDLE;
            end
            MISS_REQ, BYPASS_REQ: begin
                miss_valid_o  = 1'b1;
                miss_bypass_o = (state_q == BYPASS_REQ);
                miss_we_o     = we_q;
                miss_addr_o   = {tag_q, index_q};
                miss_be_o     = be_q;
                miss_size_o   = size_q;
                miss_wdata_o  = wdata_q;
                if (state_q == MISS_REQ && miss_gnt_i)     state_d = WAIT_REFILL;
                if (state_q == BYPASS_REQ && bypass_gnt_i) state_d = BYPASS_WAIT;
            end
            WAIT_REFILL: begin
                if (!we_q) begin
                    if (active_serving_i && critical_word_valid_i) begin
                        req_rvalid_o = 1'b1;
                        req_rdata_o  = critical_word_i;
                        state_d      = IDLE;
                    end
                end else if (serving_q && !active_serving_i) begin
                    // refill finished: the store is replayed and will now hit
                    state_d = WAIT_MSHR;
                end
            end
            WAIT_MSHR: begin
                if (!mshr_index_matches_i) begin
                    sram_req_o  = '1;
                    sram_addr_o = index_q;
                    if (sram_gnt_i) state_d = WAIT_TAG;
                end
            end
            BYPASS_WAIT: begin
                if (bypass_valid_i) begin
                    req_rvalid_o = !we_q;
                    req_rdata_o  = we_q ? 64'd0 : bypass_data_i;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            index_q     <= '0;
            tag_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            way_q       <= '0;
            tag_saved_q <= 1'b0;
            serving_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            serving_q <= active_serving_i;
            if (save_req) begin
                index_q     <= req_index_i;
                we_q        <= req_we_i;
                be_q        <= req_be_i;
                size_q      <= req_size_i;
                wdata_q     <= req_wdata_i;
                tag_saved_q <= 1'b0;
            end
            if (save_tag) begin
                tag_q       <= tag_cur;
                tag_saved_q <= 1'b1;
            end
            if (save_way) way_q <= hit_way_i;
        end
    end

endmodule

// File: tb/tb_nbdcache_port_ctrl.sv
module tb_nbdcache_port_ctrl;
    localparam int SA = 8;
    localparam int IW = 12;
    localparam int TW = 44;
    localparam int LW = 128;
    localparam int NW = LW / 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, bypass, req_valid, req_we, req_kill, req_tag_valid;
    logic [IW-1:0]       req_index;
    logic [TW-1:0]       req_tag;
    logic [7:0]          req_be;
    logic [1:0]          req_size;
    logic [63:0]         req_wdata;
    logic                sram_gnt;
    logic [SA*LW-1:0]    sram_rdata;
    logic [SA-1:0]       hit_way;
    logic                miss_gnt, bypass_gnt, bypass_valid, active_serving, cw_valid;
    logic [63:0]         bypass_data, critical_word;
    logic                mshr_addr_matches, mshr_index_matches;

    logic                busy, req_gnt, req_rvalid;
    logic [63:0]         req_rdata;
    logic [SA-1:0]       sram_req;
    logic [IW-1:0]       sram_addr;
    logic [TW-1:0]       sram_tag;
    logic                sram_we, sram_dirty;
    logic [LW-1:0]       sram_wdata;
    logic [LW/8-1:0]     sram_be;
    logic                miss_valid, miss_bypass, miss_we;
    logic [TW+IW-1:0]    miss_addr, mshr_addr;
    logic [7:0]          miss_be;
    logic [1:0]          miss_size;
    logic [63:0]         miss_wdata;

    nbdcache_port_ctrl dut (
        .clk_i(clk), .rst_i(rst), .bypass_i(bypass), .busy_o(busy),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_kill_i(req_kill),
        .req_tag_valid_i(req_tag_valid), .req_index_i(req_index), .req_tag_i(req_tag),
        .req_be_i(req_be), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .req_gnt_o(req_gnt), .req_rvalid_o(req_rvalid), .req_rdata_o(req_rdata),
        .sram_req_o(sram_req), .sram_addr_o(sram_addr), .sram_gnt_i(sram_gnt),
        .sram_rdata_i(sram_rdata), .hit_way_i(hit_way), .sram_tag_o(sram_tag),
        .sram_we_o(sram_we), .sram_dirty_o(sram_dirty), .sram_wdata_o(sram_wdata),
        .sram_be_o(sram_be), .miss_valid_o(miss_valid), .miss_bypass_o(miss_bypass),
        .miss_we_o(miss_we), .miss_addr_o(miss_addr), .miss_be_o(miss_be),
        .miss_size_o(miss_size), .miss_wdata_o(miss_wdata), .miss_gnt_i(miss_gnt),
        .bypass_gnt_i(bypass_gnt), .bypass_valid_i(bypass_valid),
        .active_serving_i(active_serving), .critical_word_valid_i(cw_valid),
        .bypass_data_i(bypass_data), .critical_word_i(critical_word),
        .mshr_addr_o(mshr_addr), .mshr_addr_matches_i(mshr_addr_matches),
        .mshr_index_matches_i(mshr_index_matches)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] line_mem [SA][NW];

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bypass = 0; req_valid = 0; req_we = 0; req_kill = 0; req_tag_valid = 0;
        req_index = '0; req_tag = '0; req_be = '0; req_size = '0; req_wdata = '0;
        sram_gnt = 0; hit_way = '0; miss_gnt = 0; bypass_gnt = 0; bypass_valid = 0;
        active_serving = 0; cw_valid = 0; bypass_data = '0; critical_word = '0;
        mshr_addr_matches = 0; mshr_index_matches = 0;
    endtask

    // Fresh random contents for every way; the array keeps presenting them.
    task automatic fill_lines();
        for (int w = 0; w < SA; w++)
            for (int k = 0; k < NW; k++) begin
                line_mem[w][k] = {$urandom, $urandom};
                sram_rdata[(w*NW+k)*64 +: 64] = line_mem[w][k];
            end
    endtask

    function automatic logic [63:0] exp_word(input logic [IW-1:0] idx, input int way);
        return line_mem[way][(int'(idx) / 8) % NW];
    endfunction

    function automatic logic [TW+IW-1:0] exp_addr(input logic [TW-1:0] tag, input logic [IW-1:0] idx);
        return (TW+IW)'(tag) * (TW+IW)'(1 << IW) + (TW+IW)'(idx);
    endfunction

    task automatic issue(input logic [IW-1:0] idx, input logic we, input logic [7:0] be,
                         input logic [1:0] sz, input logic [63:0] wd, input int gwait);
        req_valid = 1; req_we = we; req_index = idx; req_be = be; req_size = sz; req_wdata = wd;
        for (int i = 0; i < gwait; i++) begin
            sram_gnt = 0; settle();
            chk("idle_sram_req", 128'(sram_req), 128'({SA{1'b1}}));
            chk("gnt_without_sram_gnt", 128'(req_gnt), 128'(0));
            tick();
        end
        sram_gnt = 1; settle();
        chk("req_gnt", 128'(req_gnt), 128'(1));
        chk("sram_addr", 128'(sram_addr), 128'(idx));
        tick();
        req_valid = 0; sram_gnt = 0; req_we = 0; req_be = '0; req_wdata = '0; req_size = '0;
    endtask

    task automatic present_tag(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                               input logic [SA-1:0] hit, input int delay);
        for (int i = 0; i < delay; i++) begin
            settle();
            chk("wait_tag_busy", 128'(busy), 128'(1));
            chk("wait_tag_no_rvalid", 128'(req_rvalid), 128'(0));
            tick();
        end
        req_tag_valid = 1; req_tag = tag; hit_way = hit; settle();
        chk("sram_tag", 128'(sram_tag), 128'(tag));
        chk("mshr_addr", 128'(mshr_addr), 128'(exp_addr(tag, idx)));
    endtask

    task automatic clear_tag();
        req_tag_valid = 0; req_tag = '0; hit_way = '0;
    endtask

    task automatic end_idle();
        settle();
        chk("back_idle", 128'(busy), 128'(0));
        chk("idle_rvalid", 128'(req_rvalid), 128'(0));
    endtask

    task automatic t_load_hit(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input int way, input int delay);
        fill_lines();
        issue(idx, 0, 8'hFF, 2'd3, 64'd0, $urandom_range(0, 1));
        present_tag(idx, tag, SA'(1) << way, delay);
        chk("hit_rvalid", 128'(req_rvalid), 128'(1));
        chk("hit_rdata", 128'(req_rdata), 128'(exp_word(idx, way)));
        chk("hit_no_miss", 128'(miss_valid), 128'(0));
        tick(); clear_tag(); end_idle();
    endtask

    task automatic t_store_hit(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input int way,
                               input logic [7:0] be, input logic [63:0] wd, input int gwait);
        logic [LW/8-1:0] ebe;
        ebe = (LW/8)'(be) << (8 * ((int'(idx) / 8) % NW));
        fill_lines();
        issue(idx, 1, be, 2'd2, wd, 0);
        present_tag(idx, tag, SA'(1) << way, 0);
        chk("store_hit_no_rvalid", 128'(req_rvalid), 128'(0));
        tick(); clear_tag();
        for (int i = 0; i <= gwait; i++) begin
            sram_gnt = (i == gwait); settle();
            chk("store_sram_req", 128'(sram_req), 128'(SA'(1) << way));
            chk("store_sram_addr", 128'(sram_addr), 128'(idx));
            chk("store_we", 128'(sram_we), 128'(1));
            chk("store_dirty", 128'(sram_dirty), 128'(1));
            chk("store_be", 128'(sram_be), 128'(ebe));
            chk("store_wdata", 128'(sram_wdata), 128'({wd, wd}));
            chk("store_no_rvalid", 128'(req_rvalid), 128'(0));
            tick();
        end
        sram_gnt = 0; end_idle();
    endtask

    task automatic miss_req_phase(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic we,
                                  input logic [7:0] be, input logic [63:0] wd, input int gwait);
        for (int i = 0; i <= gwait; i++) begin
            miss_gnt = (i == gwait); settle();
            chk("miss_valid", 128'(miss_valid), 128'(1));
            chk("miss_bypass_low", 128'(miss_bypass), 128'(0));
            chk("miss_addr", 128'(miss_addr), 128'(exp_addr(tag, idx)));
            chk("miss_we", 128'(miss_we), 128'(we));
            chk("miss_be", 128'(miss_be), 128'(be));
            chk("miss_wdata", 128'(miss_wdata), 128'(wd));
            tick();
        end
        miss_gnt = 0;
    endtask

    task automatic t_load_miss(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                               input logic [63:0] cw, input int gwait);
        fill_lines();
        issue(idx, 0, 8'hFF, 2'd3, 64'd0, 0);
        present_tag(idx, tag, '0, $urandom_range(0, 2));
        chk("miss_no_rvalid", 128'(req_rvalid), 128'(0));
        tick(); clear_tag();
        miss_req_phase(idx, tag, 0, 8'hFF, 64'd0, gwait);
        active_serving = 1; cw_valid = 0; settle();
        chk("refill_no_rvalid", 128'(req_rvalid), 128'(0));
        chk("refill_miss_dropped", 128'(miss_valid), 128'(0));
        chk("refill_busy", 128'(busy), 128'(1));
        tick();
        cw_valid = 1; critical_word = cw; settle();
        chk("refill_rvalid", 128'(req_rvalid), 128'(1));
        chk("refill_rdata", 128'(req_rdata), 128'(cw));
        tick();
        active_serving = 0; cw_valid = 0; critical_word = '0;
        end_idle();
    endtask

    task automatic t_store_miss(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input int way,
                                input logic [7:0] be, input logic [63:0] wd);
        logic [LW/8-1:0] ebe;
        ebe = (LW/8)'(be) << (8 * ((int'(idx) / 8) % NW));
        fill_lines();
        issue(idx, 1, be, 2'd3, wd, 0);
        present_tag(idx, tag, '0, 0);
        tick(); clear_tag();
        miss_req_phase(idx, tag, 1, be, wd, $urandom_range(0, 2));
        active_serving = 1; settle();
        chk("store_refill_busy", 128'(busy), 128'(1));
        tick();
        active_serving = 0; settle();
        chk("store_refill_no_rvalid", 128'(req_rvalid), 128'(0));
        tick();
        sram_gnt = 1; settle();
        chk("replay_sram_req", 128'(sram_req), 128'({SA{1'b1}}));
        chk("replay_sram_addr", 128'(sram_addr), 128'(idx));
        chk("replay_no_req_gnt", 128'(req_gnt), 128'(0));
        tick();
        sram_gnt = 0; req_tag = ~tag; hit_way = SA'(1) << way; settle();
        chk("replay_saved_tag", 128'(sram_tag), 128'(tag));
        chk("replay_store_no_rvalid", 128'(req_rvalid), 128'(0));
        tick(); clear_tag();
        sram_gnt = 1; settle();
        chk("replay_store_req", 128'(sram_req), 128'(SA'(1) << way));
        chk("replay_store_we", 128'(sram_we), 128'(1));
        chk("replay_store_be", 128'(sram_be), 128'(ebe));
        chk("replay_store_wdata", 128'(sram_wdata), 128'({wd, wd}));
        tick(); sram_gnt = 0;
        end_idle();
    endtask

    task automatic t_bypass(input logic we, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input logic [7:0] be, input logic [1:0] sz, input logic [63:0] wd,
                            input logic [63:0] data, input int gwait);
        fill_lines();
        bypass = 1;
        issue(idx, we, be, sz, wd, 0);
        present_tag(idx, tag, SA'(1) << $urandom_range(0, SA-1), 0);
        chk("bypass_no_hit_rvalid", 128'(req_rvalid), 128'(0));
        tick(); clear_tag();
        for (int i = 0; i <= gwait; i++) begin
            bypass_gnt = (i == gwait); settle();
            chk("bypass_valid", 128'(miss_valid), 128'(1));
            chk("bypass_flag", 128'(miss_bypass), 128'(1));
            chk("bypass_addr", 128'(miss_addr), 128'(exp_addr(tag, idx)));
            chk("bypass_we", 128'(miss_we), 128'(we));
            chk("bypass_be", 128'(miss_be), 128'(be));
            chk("bypass_size", 128'(miss_size), 128'(sz));
            chk("bypass_wdata", 128'(miss_wdata), 128'(wd));
            tick();
        end
        bypass_gnt = 0; settle();
        chk("bypass_wait_no_rvalid", 128'(req_rvalid), 128'(0));
        chk("bypass_wait_no_miss", 128'(miss_valid), 128'(0));
        tick();
        bypass_valid = 1; bypass_data = data; settle();
        chk("bypass_rvalid", 128'(req_rvalid), 128'(!we));
        if (!we) chk("bypass_rdata", 128'(req_rdata), 128'(data));
        chk("bypass_no_array_write", 128'(sram_we), 128'(0));
        tick();
        bypass_valid = 0; bypass_data = '0; bypass = 0;
        end_idle();
    endtask

    task automatic t_kill(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [SA-1:0] hit);
        fill_lines();
        issue(idx, 0, 8'hFF, 2'd3, 64'd0, 0);
        req_kill = 1;
        present_tag(idx, tag, hit, 0);
        chk("kill_no_rvalid", 128'(req_rvalid), 128'(0));
        chk("kill_no_miss", 128'(miss_valid), 128'(0));
        tick(); req_kill = 0; clear_tag();
        end_idle();
        chk("kill_no_miss_after", 128'(miss_valid), 128'(0));
    endtask

    task automatic t_conflict(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input int way, input int n);
        fill_lines();
        issue(idx, 0, 8'hFF, 2'd3, 64'd0, 0);
        mshr_index_matches = 1;
        present_tag(idx, tag, SA'(1) << way, 0);
        chk("conflict_no_rvalid", 128'(req_rvalid), 128'(0));
        tick(); clear_tag();
        for (int i = 0; i < n; i++) begin
            settle();
            chk("conflict_hold_no_sram", 128'(sram_req), 128'(0));
            chk("conflict_hold_busy", 128'(busy), 128'(1));
            chk("conflict_hold_no_rvalid", 128'(req_rvalid), 128'(0));
            tick();
        end
        mshr_index_matches = 0; sram_gnt = 1; settle();
        chk("conflict_rerequest", 128'(sram_req), 128'({SA{1'b1}}));
        chk("conflict_rerequest_addr", 128'(sram_addr), 128'(idx));
        tick();
        sram_gnt = 0; req_tag = ~tag; hit_way = SA'(1) << way; settle();
        chk("conflict_saved_tag", 128'(sram_tag), 128'(tag));
        chk("conflict_replay_rvalid", 128'(req_rvalid), 128'(1));
        chk("conflict_replay_rdata", 128'(req_rdata), 128'(exp_word(idx, way)));
        tick(); clear_tag();
        end_idle();
    endtask

    initial begin
        idle_inputs();
        sram_rdata = '0;
        rst = 1;
        tick(); tick();
        settle();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_gnt", 128'(req_gnt), 128'(0));
        chk("rst_rvalid", 128'(req_rvalid), 128'(0));
        chk("rst_sram_req", 128'(sram_req), 128'(0));
        chk("rst_miss_valid", 128'(miss_valid), 128'(0));
        chk("rst_sram_tag", 128'(sram_tag), 128'(0));
        chk("rst_mshr_addr", 128'(mshr_addr), 128'(0));
        rst = 0;
        tick();

        t_load_hit(12'h040, 44'h123_4567_89AB, 2, 1);
        t_store_hit(12'h048, 44'h0AB_CDEF_0123, 5, 8'h0F, 64'h0000_0000_DEAD_BEEF, 1);
        t_load_miss(12'h2C8, 44'h777_0000_1111, 64'h1234, 2);
        t_bypass(0, 12'h310, 44'h0F0_F0F0_F0F0, 8'hFF, 2'd3, 64'd0, 64'hCAFE, 1);
        t_kill(12'h100, 44'h555_5555_5555, 8'h10);
        t_conflict(12'h058, 44'h321_0FED_CBA9, 7, 4);
        t_store_miss(12'h0A8, 44'h246_8ACE_1357, 3, 8'hC3, 64'h0123_4567_89AB_CDEF);
        t_bypass(1, 12'h7F8, 44'hFFF_FFFF_FFFF, 8'h3C, 2'd1, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 0);

        // reset while waiting for the tag abandons the request
        issue(12'h123, 0, 8'hFF, 2'd3, 64'd0, 0);
        rst = 1; tick(); rst = 0;
        end_idle();
        chk("rst_mid_no_miss", 128'(miss_valid), 128'(0));

        for (int it = 0; it < 40; it++) begin
            logic [IW-1:0] ridx;
            logic [TW-1:0] rtag;
            logic [63:0]   rd;
            int            rway;
            ridx = IW'($urandom);
            rtag = TW'({$urandom, $urandom});
            rd   = {$urandom, $urandom};
            rway = $urandom_range(0, SA-1);
            case ($urandom_range(0, 6))
                0: t_load_hit(ridx, rtag, rway, $urandom_range(0, 3));
                1: t_store_hit(ridx, rtag, rway, 8'($urandom), rd, $urandom_range(0, 2));
                2: t_load_miss(ridx, rtag, rd, $urandom_range(0, 3));
                3: t_store_miss(ridx, rtag, rway, 8'($urandom), rd);
                4: t_bypass(1'($urandom), ridx, rtag, 8'($urandom), 2'($urandom), rd, {$urandom, $urandom}, $urandom_range(0, 2));
                5: t_kill(ridx, rtag, SA'($urandom));
                default: t_conflict(ridx, rtag, rway, $urandom_range(1, 5));
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end
endmodule
